image_window_gen: RTL and testbench

- Front end of the filter pipeline. Accepts a raster pixel stream and stores it in four rotating line buffers.
- Emits one 72-bit 3x3 neighbourhood per cycle on outData/outDataValid, directly feeding the convolution stage's inData/inDataValid.
- Pulses an interrupt each time a line buffer is retired, so the host/DMA knows it may send one more line.

---
 rtl/image_window_gen_pkg.sv | 18 +
 rtl/image_window_gen_line_buffer.sv | 74 +++++++
 rtl/image_window_gen.sv | 149 ++++++++++++++
 tb/tb_image_window_gen.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/image_window_gen_pkg.sv
// Shared types and constants for the 3x3 window generator and its line buffers.
package img_pkg;

  localparam int PIX_W    = 8;
  localparam int WIN_W    = 72;
  localparam int NUM_LBUF = 4;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    RD_LINE = 1'b1
  } state_t;

  // One window row: element [0] is the leftmost column.
  typedef logic [2:0][PIX_W-1:0] row_t;
  // Full window: [row][col], row 0 = oldest line; packs to bits [(row*3+col)*8 +: 8].
  typedef logic [2:0][2:0][PIX_W-1:0] win_t;

endpackage

// File: rtl/image_window_gen_line_buffer.sv
// Single image line store: sequential write port, registered 3-column read port
// with the right edge replicated.
module line_buffer
  import img_pkg::*;
#(
  parameter int IMG_WIDTH = 512
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [PIX_W-1:0] wr_data,
  input  logic             wr_en,
  input  logic             rd_en,
  output row_t             rd_data
);

  localparam int               COL_W    = $clog2(IMG_WIDTH);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_WIDTH - 1);

  logic [PIX_W-1:0] mem [IMG_WIDTH];
  logic [COL_W-1:0] wr_col_q, wr_col_d;
  logic [COL_W-1:0] rd_col_q, rd_col_d;
  logic [COL_W-1:0] col1_s, col2_s;
  row_t             rd_data_q, rd_data_d;

  function automatic logic [COL_W-1:0] clamp_col(input logic [COL_W:0] col);
    if (col > {1'b0, LAST_COL}) begin
      return LAST_COL;
    end else begin
      return col[COL_W-1:0];
    end
  endfunction

  always_comb begin
    wr_col_d  = wr_col_q;
    rd_col_d  = rd_col_q;
    rd_data_d = rd_data_q;
    col1_s    = clamp_col({1'b0, rd_col_q} + (COL_W+1)'(1));
    col2_s    = clamp_col({1'b0, rd_col_q} + (COL_W+1)'(2));
    if (wr_en) begin
      wr_col_d = (wr_col_q == LAST_COL) ? '0 : wr_col_q + COL_W'(1);
    end else begin
      wr_col_d = wr_col_q;
    end
    if (rd_en) begin
      rd_col_d  = (rd_col_q == LAST_COL) ? '0 : rd_col_q + COL_W'(1);
      rd_data_d = {mem[col2_s], mem[col1_s], mem[rd_col_q]};
    end else begin
      rd_col_d  = rd_col_q;
      rd_data_d = rd_data_q;
    end
  end

  // Pixel storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_col_q] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_col_q  <= '0;
      rd_col_q  <= '0;
      rd_data_q <= '0;
    end else begin
      wr_col_q  <= wr_col_d;
      rd_col_q  <= rd_col_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/image_window_gen.sv
// Raster stream to 3x3 window generator over four rotating line buffers, with a
// per-line retire interrupt and a sticky overflow flag for dropped pixels.
module image_window_gen
  import img_pkg::*;
#(
  parameter  int IMG_WIDTH = 512,
  localparam int CNT_W     = $clog2(4*IMG_WIDTH+1)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [PIX_W-1:0] pixelData,
  input  logic             pixelDataValid,
  output logic [WIN_W-1:0] outData,
  output logic             outDataValid,
  output logic             lineDoneIntr,
  output logic             overflow
);

  localparam int               COL_W     = $clog2(IMG_WIDTH);
  localparam logic [COL_W-1:0] LAST_COL  = COL_W'(IMG_WIDTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(4*IMG_WIDTH);
  localparam logic [CNT_W-1:0] RD_THRESH = CNT_W'(3*IMG_WIDTH);

  state_t              state_q, state_d;
  logic [1:0]          wr_buf_q, wr_buf_d, rd_buf_q, rd_buf_d, out_buf_q, out_buf_d;
  logic [COL_W-1:0]    wr_col_q, wr_col_d, rd_col_q, rd_col_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                valid_q, valid_d, intr_q, intr_d, ovf_q, ovf_d;
  logic                wr_acc_s, rd_en_s;
  logic [NUM_LBUF-1:0] buf_wr_s, buf_rd_s;
  row_t                buf_data_s [NUM_LBUF];
  win_t                win_s;

  // A full set of four lines means the pixel has nowhere to go: drop it, freeze pointers.
  always_comb begin
    wr_acc_s = pixelDataValid && (cnt_q < FULL_CNT);
    wr_buf_d = wr_buf_q;
    wr_col_d = wr_col_q;
    ovf_d    = ovf_q;
    buf_wr_s = '0;
    if (wr_acc_s) begin
      buf_wr_s[wr_buf_q] = 1'b1;
      if (wr_col_q == LAST_COL) begin
        wr_col_d = '0;
        wr_buf_d = wr_buf_q + 2'd1;
      end else begin
        wr_col_d = wr_col_q + COL_W'(1);
      end
    end else if (pixelDataValid) begin
      ovf_d = 1'b1;
    end else begin
      ovf_d = ovf_q;
    end
  end

  always_comb begin
    state_d  = state_q;
    rd_col_d = rd_col_q;
    rd_buf_d = rd_buf_q;
    intr_d   = 1'b0;
    rd_en_s  = 1'b0;
    case (state_q)
      IDLE: begin
        rd_col_d = '0;
        if (cnt_q >= RD_THRESH) begin
          state_d = RD_LINE;
        end else begin
          state_d = IDLE;
        end
      end
      RD_LINE: begin
        rd_en_s = 1'b1;
        if (rd_col_q == LAST_COL) begin
          rd_col_d = '0;
          rd_buf_d = rd_buf_q + 2'd1;
          intr_d   = 1'b1;
          state_d  = IDLE;
        end else begin
          rd_col_d = rd_col_q + COL_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // The output mux must follow the buffer set that was read, not the advanced rd_buf.
  always_comb begin
    buf_rd_s = '0;
    for (int r = 0; r < 3; r++) begin
      buf_rd_s[rd_buf_q + 2'(r)] = rd_en_s;
    end
    case ({wr_acc_s, rd_en_s})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
    valid_d   = rd_en_s;
    out_buf_d = rd_en_s ? rd_buf_q : out_buf_q;
    win_s     = '0;
    for (int r = 0; r < 3; r++) begin
      win_s[r] = buf_data_s[out_buf_q + 2'(r)];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      wr_buf_q  <= 2'd0;
      rd_buf_q  <= 2'd0;
      out_buf_q <= 2'd0;
      wr_col_q  <= '0;
      rd_col_q  <= '0;
      cnt_q     <= '0;
      valid_q   <= 1'b0;
      intr_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_buf_q  <= wr_buf_d;
      rd_buf_q  <= rd_buf_d;
      out_buf_q <= out_buf_d;
      wr_col_q  <= wr_col_d;
      rd_col_q  <= rd_col_d;
      cnt_q     <= cnt_d;
      valid_q   <= valid_d;
      intr_q    <= intr_d;
      ovf_q     <= ovf_d;
    end
  end

  for (genvar b = 0; b < NUM_LBUF; b++) begin : g_lbuf
    line_buffer #(.IMG_WIDTH(IMG_WIDTH)) u_lbuf (
      .clk     (clk),
      .rstn    (rstn),
      .wr_data (pixelData),
      .wr_en   (buf_wr_s[b]),
      .rd_en   (buf_rd_s[b]),
      .rd_data (buf_data_s[b])
    );
  end

  assign outData      = win_s;
  assign outDataValid = valid_q;
  assign lineDoneIntr = intr_q;
  assign overflow     = ovf_q;

endmodule

// File: tb/tb_image_window_gen.sv
// Directed bench for image_window_gen with an 8-pixel line.
module tb_image_window_gen;

  localparam int W = 8;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [7:0]  pixelData = 8'd0;
  logic        pixelDataValid = 1'b0;
  logic [71:0] outData;
  logic        outDataValid, lineDoneIntr, overflow;

  int          checks = 0;
  int          errors = 0;
  int          intr_cnt = 0;
  logic [71:0] win_q [$];
  logic [7:0]  pix [0:127];

  image_window_gen #(.IMG_WIDTH(W)) dut (
    .clk            (clk),
    .rstn           (rstn),
    .pixelData      (pixelData),
    .pixelDataValid (pixelDataValid),
    .outData        (outData),
    .outDataValid   (outDataValid),
    .lineDoneIntr   (lineDoneIntr),
    .overflow       (overflow)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rstn) begin
      if (outDataValid) win_q.push_back(outData);
      if (lineDoneIntr) intr_cnt++;
    end
  end

  task automatic check_eq(input string tag, input logic [71:0] got, input logic [71:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [71:0] exp_win(input int k, input int c);
    logic [71:0] w;
    w = '0;
    for (int r = 0; r < 3; r++) begin
      for (int j = 0; j < 3; j++) begin
        int col;
        col = (c + j > W - 1) ? W - 1 : c + j;
        w[(r*3+j)*8 +: 8] = pix[(k+r)*W + col];
      end
    end
    return w;
  endfunction

  function automatic logic [71:0] get_win(input int i);
    if (i < win_q.size()) return win_q[i];
    else return 72'hx;
  endfunction

  function automatic logic [7:0] wbyte(input int idx, input int pos);
    logic [71:0] w;
    w = win_q[idx];
    return w[pos*8 +: 8];
  endfunction

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_win(input int n, input int budget);
    for (int i = 0; i < budget && win_q.size() < n; i++) @(posedge clk);
    #1;
  endtask

  task automatic send_pix(input logic [7:0] v, input int gap);
    pixelData      = v;
    pixelDataValid = 1'b1;
    @(posedge clk);
    #1;
    pixelDataValid = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_range(input int first, input int n, input int maxgap);
    for (int i = 0; i < n; i++)
      send_pix(pix[first+i], (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0);
  endtask

  task automatic do_reset();
    pixelDataValid = 1'b0;
    pixelData      = 8'd0;
    rstn           = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    win_q.delete();
    intr_cnt = 0;
    rstn     = 1'b1;
  endtask

  task automatic run_s1(input string p);
    for (int i = 0; i < 24; i++) pix[i] = 8'(i);
    send_range(0, 24, 0);
    wait_win(8, 60);
    wait_cycles(10);
    check_eq({p, "_count"}, win_q.size(), 8);
    check_eq({p, "_first"}, get_win(0), 72'h121110_0a0908_020100);
    check_eq({p, "_last"},  get_win(7), 72'h171717_0f0f0f_070707);
    for (int c = 1; c < 7; c++) check_eq({p, "_win"}, get_win(c), exp_win(0, c));
    check_eq({p, "_intr"}, intr_cnt, 1);
    check_eq({p, "_ovf"}, overflow, 1'b0);
  endtask

  initial begin
    int n, nl, errs;
    logic [7:0] seq [$];

    // reset values
    do_reset();
    check_eq("rst_data", outData, 72'h0);
    check_eq("rst_valid", outDataValid, 1'b0);
    check_eq("rst_intr", lineDoneIntr, 1'b0);
    check_eq("rst_ovf", overflow, 1'b0);

    // three lines -> one output line
    run_s1("s1");

    // 32 more pixels continuously: four more output lines, no drops
    for (int i = 24; i < 56; i++) pix[i] = 8'(i);
    send_range(24, 32, 0);
    wait_win(40, 200);
    wait_cycles(20);
    check_eq("s2_count", win_q.size(), 40);
    check_eq("s2_line1_first", get_win(8), 72'h1a1918_121110_0a0908);
    for (int i = 8; i < 40; i++) check_eq("s2_win", get_win(i), exp_win(i / 8, i % 8));
    check_eq("s2_intr", intr_cnt, 5);
    check_eq("s2_ovf", overflow, 1'b0);

    // flood the input until pixels are dropped
    do_reset();
    for (int i = 0; i < 100; i++) pix[i] = 8'(i);
    send_range(0, 100, 0);
    wait_cycles(150);
    check_eq("s3_ovf", overflow, 1'b1);
    n = win_q.size();
    check_eq("s3_lines", (n >= 24) && (n % 8 == 0), 1'b1);
    nl = n / 8;
    errs = 0;
    for (int k = 0; k < nl; k++)
      for (int c = 0; c < 8; c++)
        for (int r = 0; r < 3; r++)
          for (int j = 0; j < 3; j++)
            if (wbyte(k*8+c, r*3+j) !== wbyte(k*8 + ((c+j > 7) ? 7 : c+j), r*3)) errs++;
    check_eq("s3_clamp", errs, 0);
    errs = 0;
    for (int k = 0; k + 1 < nl; k++)
      for (int c = 0; c < 8; c++) begin
        if (wbyte(k*8+c, 3) !== wbyte((k+1)*8+c, 0)) errs++;
        if (wbyte(k*8+c, 6) !== wbyte((k+1)*8+c, 3)) errs++;
      end
    check_eq("s3_chain", errs, 0);
    seq.delete();
    for (int k = 0; k < nl; k++)
      for (int r = 0; r < 3; r++)
        if (k == 0 || r == 2)
          for (int c = 0; c < 8; c++) seq.push_back(wbyte(k*8+c, r*3));
    errs = 0;
    for (int i = 0; i < seq.size(); i++) begin
      if (i < 24 && seq[i] !== 8'(i)) errs++;
      if (i > 0 && seq[i] <= seq[i-1]) errs++;
    end
    check_eq("s3_order", errs, 0);
    wait_cycles(20);
    check_eq("s3_ovf_sticky", overflow, 1'b1);

    // asynchronous reset in the middle of an output line
    do_reset();
    for (int i = 0; i < 24; i++) pix[i] = 8'(i);
    send_range(0, 24, 0);
    wait_win(4, 60);
    check_eq("s4_pre_valid", outDataValid, 1'b1);
    #2;
    rstn = 1'b0;
    #1;
    check_eq("s4_rst_data", outData, 72'h0);
    check_eq("s4_rst_valid", outDataValid, 1'b0);
    check_eq("s4_rst_intr", lineDoneIntr, 1'b0);
    @(posedge clk);
    #1;
    win_q.delete();
    intr_cnt = 0;
    rstn = 1'b1;
    run_s1("s4");

    // random gaps, host sends one line per interrupt after four up front
    do_reset();
    for (int i = 0; i < 80; i++) pix[i] = 8'((i * 37 + 11) & 255);
    send_range(0, 32, 2);
    for (int l = 4; l < 10; l++) begin
      for (int i = 0; i < 400 && intr_cnt < l - 3; i++) @(posedge clk);
      #1;
      check_eq("s5_intr_wait", intr_cnt >= l - 3, 1'b1);
      send_range(l*8, 8, 2);
    end
    wait_win(64, 600);
    wait_cycles(30);
    check_eq("s5_count", win_q.size(), 64);
    for (int i = 0; i < 64; i++) check_eq("s5_win", get_win(i), exp_win(i / 8, i % 8));
    check_eq("s5_intr", intr_cnt, 8);
    check_eq("s5_ovf", overflow, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
